// File: rtl/ss_hps_pkg.sv
// Shared constants and state encoding for the hps_io block-device responder.
package ss_hps_pkg;

  localparam int SECTOR_WORDS  = 256;
  localparam int QW_PER_SECTOR = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    RD_EMIT,
    ZERO_EMIT,
    WR_FETCH,
    WR_REQ,
    DONE
  } resp_state_t;

endpackage

// File: rtl/ss_ramdisk_burstbuf.sv
// Holds one DDRAM read burst; the emitter reads it back one 16-bit word at a time.
module ss_ramdisk_burstbuf #(
  parameter int BURST = 8,
  parameter int IW    = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [IW-1:0] q_off,
  input  logic [1:0]    k,
  output logic [15:0]   rdata
);

  logic [63:0] mem [BURST];

  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[q_off][{k, 4'b0000} +: 16];

endmodule

// File: rtl/ss_ramdisk_resp.sv
// hps_io block-device responder: serves 512-byte sectors from a disk image held in DDRAM.
module ss_ramdisk_resp
  import ss_hps_pkg::*;
#(
  parameter logic [28:0] BASE  = 29'h0800000,
  parameter int          BURST = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [15:0] sd_buff_din,
  output logic        ddram_clk,
  input  logic        ddram_waitrequest,
  output logic [7:0]  ddram_burstcount,
  output logic [28:0] ddram_address,
  output logic        ddram_read,
  output logic        ddram_write,
  input  logic [63:0] ddram_readdata,
  input  logic        ddram_readdatavalid,
  output logic [63:0] ddram_writedata,
  output logic [7:0]  ddram_byteenable
);

  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  resp_state_t state;
  logic [31:0] size_sectors;
  logic [22:0] lba;
  logic [6:0]  q;
  logic [7:0]  cnt;
  logic [47:0] wr_qw;
  logic [1:0]  wr_lane;
  logic [15:0] buf_word;
  logic        buf_we;
  logic        img_size_unused;

  assign ddram_clk        = clk_sys;
  assign ddram_byteenable = 8'hFF;
  assign img_size_unused  = ^{img_size[63:41], img_size[8:0]};
  assign buf_we           = (state == RD_DATA) && ddram_readdatavalid;
  // din arrives two cycles after the fetch counter that produced its address
  assign wr_lane          = cnt[1:0] - 2'd2;

  function automatic logic [28:0] qw_addr(input logic [22:0] l, input logic [6:0] qq);
    return BASE + {l, 6'b000000} + {22'b0, qq};
  endfunction

  ss_ramdisk_burstbuf #(.BURST(BURST), .IW(IW)) u_buf (
    .clk_sys (clk_sys),
    .we      (buf_we),
    .waddr   (cnt[IW-1:0]),
    .wdata   (ddram_readdata),
    .q_off   (cnt[IW+1:2]),
    .k       (cnt[1:0]),
    .rdata   (buf_word)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= IDLE;
      size_sectors     <= '0;
      lba              <= '0;
      q                <= '0;
      cnt              <= '0;
      wr_qw            <= '0;
      sd_ack           <= 1'b0;
      sd_buff_addr     <= '0;
      sd_buff_dout     <= '0;
      sd_buff_wr       <= 1'b0;
      ddram_read       <= 1'b0;
      ddram_write      <= 1'b0;
      ddram_address    <= '0;
      ddram_burstcount <= '0;
      ddram_writedata  <= '0;
    end else begin
      sd_buff_wr <= 1'b0;
      if (img_mounted) size_sectors <= img_size[40:9];

      case (state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            lba    <= sd_lba[22:0];
            q      <= '0;
            cnt    <= '0;
            sd_ack <= 1'b1;
            if (sd_rd) begin
              if (sd_lba < size_sectors) begin
                state            <= RD_REQ;
                ddram_read       <= 1'b1;
                ddram_burstcount <= 8'(BURST);
                ddram_address    <= qw_addr(sd_lba[22:0], 7'd0);
              end else begin
                state <= ZERO_EMIT;
              end
            end else begin
              state <= (sd_lba < size_sectors) ? WR_FETCH : DONE;
            end
          end
        end

        RD_REQ: begin
          if (!ddram_waitrequest) begin
            ddram_read <= 1'b0;
            cnt        <= '0;
            state      <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (ddram_readdatavalid) begin
            if (cnt == 8'(BURST - 1)) begin
              cnt   <= '0;
              state <= RD_EMIT;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        RD_EMIT: begin
          sd_buff_wr   <= 1'b1;
          sd_buff_addr <= {q[5:0], 2'b00} + cnt;
          sd_buff_dout <= buf_word;
          cnt          <= cnt + 8'd1;
          if (cnt == 8'(4 * BURST - 1)) begin
            cnt <= '0;
            q   <= q + 7'(BURST);
            if (q + 7'(BURST) == 7'(QW_PER_SECTOR)) begin
              state <= DONE;
            end else begin
              state            <= RD_REQ;
              ddram_read       <= 1'b1;
              ddram_burstcount <= 8'(BURST);
              ddram_address    <= qw_addr(lba, q + 7'(BURST));
            end
          end
        end

        ZERO_EMIT: begin
          sd_buff_wr   <= 1'b1;
          sd_buff_addr <= cnt;
          sd_buff_dout <= '0;
          cnt          <= cnt + 8'd1;
          if (cnt == 8'(SECTOR_WORDS - 1)) state <= DONE;
        end

        WR_FETCH: begin
          if (cnt < 8'd4) sd_buff_addr <= {q[5:0], 2'b00} + cnt;
          if (cnt >= 8'd2 && cnt < 8'd5) wr_qw[{wr_lane, 4'b0000} +: 16] <= sd_buff_din;
          if (cnt == 8'd5) begin
            cnt              <= '0;
            state            <= WR_REQ;
            ddram_write      <= 1'b1;
            ddram_burstcount <= 8'd1;
            ddram_address    <= qw_addr(lba, q);
            ddram_writedata  <= {sd_buff_din, wr_qw};
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        WR_REQ: begin
          if (!ddram_waitrequest) begin
            ddram_write <= 1'b0;
            q           <= q + 7'd1;
            cnt         <= '0;
            state       <= (q == 7'(QW_PER_SECTOR - 1)) ? DONE : WR_FETCH;
          end
        end

        DONE: begin
          // a request level still held from the finished transfer must not retrigger
          sd_ack <= 1'b0;
          if (!sd_rd && !sd_wr) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_ramdisk_resp.sv
// Directed bench for ss_ramdisk_resp against a behavioural DDRAM and hps_io client model.
module tb_ss_ramdisk_resp;

  localparam logic [28:0] BASE  = 29'h0800000;
  localparam int          BURST = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout, sd_buff_din;
  logic        ddram_clk, ddram_waitrequest, ddram_read, ddram_write, ddram_readdatavalid;
  logic [7:0]  ddram_burstcount, ddram_byteenable;
  logic [28:0] ddram_address;
  logic [63:0] ddram_readdata, ddram_writedata;

  always #5 clk_sys = ~clk_sys;

  ss_ramdisk_resp #(.BASE(BASE), .BURST(BURST)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .ddram_clk(ddram_clk), .ddram_waitrequest(ddram_waitrequest),
    .ddram_burstcount(ddram_burstcount), .ddram_address(ddram_address),
    .ddram_read(ddram_read), .ddram_write(ddram_write), .ddram_readdata(ddram_readdata),
    .ddram_readdatavalid(ddram_readdatavalid), .ddram_writedata(ddram_writedata),
    .ddram_byteenable(ddram_byteenable)
  );

  typedef struct {
    bit          mount;
    longint      size;
    bit          rd;
    bit          wr;
    int          lba;
    bit          stall;
    int          kind;
    int          words;
    int          rdc;
    int          wrc;
    int          ackc;
  } vec_t;

  vec_t vecs[13];

  int checks = 0, passes = 0;
  int rx_cnt, seq_err, proto_err, stable_err, cmd_err, stall_cnt;
  int ack_cycles, ack_rises, rd_cmds, wr_cmds, cur_lba, gap;
  bit stall_en, prev_ack, prev_stall;
  logic [15:0]  rx [256];
  logic [7:0]   din_addr;
  logic [110:0] prev_cmd;
  logic [63:0]  mem [logic [28:0]];
  logic [28:0]  rd_q [$];

  function automatic logic [63:0] memRead(input logic [28:0] a);
    return mem.exists(a) ? mem[a] : {35'b0, a};
  endfunction

  // kind 0 = untouched image (word(a)=a), 1 = zero fill, 2 = written pattern addr^A5A5
  function automatic logic [15:0] expWord(input int kind, input int lba, input int i);
    logic [28:0] a;
    logic [63:0] qw;
    case (kind)
      0: begin
        a  = BASE + 29'(lba * 64) + 29'(i / 4);
        qw = {35'b0, a};
        return qw[16 * (i % 4) +: 16];
      end
      2: return 16'(i) ^ 16'hA5A5;
      default: return 16'h0000;
    endcase
  endfunction

  // Client capture, registered din, DDRAM responder and command-protocol monitor
  always @(negedge clk_sys) begin
    logic [28:0] ea;
    logic [63:0] ed;
    if (sd_buff_wr) begin
      if (!sd_ack) proto_err++;
      if (sd_buff_addr != 8'(rx_cnt)) seq_err++;
      if (rx_cnt < 256) rx[rx_cnt] = sd_buff_dout;
      rx_cnt++;
    end
    if (sd_ack) ack_cycles++;
    if (sd_ack && !prev_ack) ack_rises++;
    prev_ack    = sd_ack;
    sd_buff_din = {8'h00, din_addr} ^ 16'hA5A5;
    din_addr    = sd_buff_addr;

    if (rd_q.size() > 0 && gap == 0) begin
      ddram_readdatavalid = 1'b1;
      ddram_readdata      = memRead(rd_q.pop_front());
      gap                 = stall_en ? int'($urandom_range(0, 5)) : 0;
    end else begin
      ddram_readdatavalid = 1'b0;
      if (gap > 0) gap--;
    end

    if (!reset && prev_stall &&
        {ddram_read, ddram_write, ddram_address, ddram_burstcount, ddram_writedata} != prev_cmd)
      stable_err++;
    if (ddram_read && ddram_write) proto_err++;
    ddram_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    prev_stall = 1'b0;
    if (!reset && (ddram_read || ddram_write)) begin
      if (ddram_waitrequest) begin
        prev_stall = 1'b1;
        prev_cmd   = {ddram_read, ddram_write, ddram_address, ddram_burstcount, ddram_writedata};
        stall_cnt++;
      end else if (ddram_read) begin
        ea = BASE + 29'(cur_lba * 64) + 29'(rd_cmds * BURST);
        if (ddram_address != ea || ddram_burstcount != 8'(BURST)) cmd_err++;
        for (int b = 0; b < BURST; b++) rd_q.push_back(ddram_address + 29'(b));
        rd_cmds++;
      end else begin
        ea = BASE + 29'(cur_lba * 64) + 29'(wr_cmds);
        for (int k = 0; k < 4; k++) ed[16 * k +: 16] = 16'(4 * wr_cmds + k) ^ 16'hA5A5;
        if (ddram_address != ea || ddram_writedata != ed || ddram_burstcount != 8'd1 ||
            ddram_byteenable != 8'hFF) cmd_err++;
        mem[ddram_address] = ddram_writedata;
        wr_cmds++;
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clearCounters();
    rx_cnt = 0; seq_err = 0; cmd_err = 0; ack_cycles = 0; ack_rises = 0;
    rd_cmds = 0; wr_cmds = 0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk_sys);
    clearCounters();
    cur_lba  = v.lba;
    stall_en = v.stall;
    if (v.mount) begin
      img_size    = 64'(v.size);
      img_mounted = 1'b1;
      @(negedge clk_sys);
      img_mounted = 1'b0;
    end
    sd_lba = 32'(v.lba);
    sd_rd  = v.rd;
    sd_wr  = v.wr;
    for (int n = 0; n < 50 && !sd_ack; n++) @(negedge clk_sys);
    checkOutput({tag, "_ack_start"}, sd_ack, 1);
    for (int n = 0; n < 40000 && sd_ack; n++) @(negedge clk_sys);
    checkOutput({tag, "_ack_end"}, sd_ack, 0);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    stall_en = 1'b0;
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    int data_err = 0;
    for (int i = 0; i < rx_cnt && i < 256; i++)
      if (rx[i] !== expWord(v.kind, v.lba, i)) data_err++;
    checkOutput({tag, "_ack_rises"}, ack_rises, 1);
    checkOutput({tag, "_words"}, rx_cnt, v.words);
    checkOutput({tag, "_data_err"}, data_err, 0);
    checkOutput({tag, "_addr_seq_err"}, seq_err, 0);
    checkOutput({tag, "_ddram_reads"}, rd_cmds, v.rdc);
    checkOutput({tag, "_ddram_writes"}, wr_cmds, v.wrc);
    checkOutput({tag, "_cmd_err"}, cmd_err, 0);
    if (v.ackc >= 0) checkOutput({tag, "_ack_cycles"}, ack_cycles, v.ackc);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; img_mounted = 1'b0; img_size = '0; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
    sd_buff_din = '0; ddram_waitrequest = 1'b0; ddram_readdatavalid = 1'b0; ddram_readdata = '0;
    din_addr = '0; prev_cmd = '0; gap = 0; stall_en = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0;
    proto_err = 0; stable_err = 0; stall_cnt = 0; cur_lba = 0;
    clearCounters();

    vecs[0]  = '{mount:1, size:1048576, rd:1, wr:0, lba:3,    stall:0, kind:0, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[1]  = '{mount:0, size:0,       rd:0, wr:1, lba:5,    stall:0, kind:3, words:0,   rdc:0, wrc:64, ackc:-1};
    vecs[2]  = '{mount:0, size:0,       rd:1, wr:0, lba:5,    stall:0, kind:2, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[3]  = '{mount:0, size:0,       rd:1, wr:0, lba:0,    stall:1, kind:0, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[4]  = '{mount:0, size:0,       rd:0, wr:1, lba:6,    stall:1, kind:3, words:0,   rdc:0, wrc:64, ackc:-1};
    vecs[5]  = '{mount:0, size:0,       rd:1, wr:0, lba:6,    stall:1, kind:2, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[6]  = '{mount:0, size:0,       rd:1, wr:1, lba:3,    stall:0, kind:0, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[7]  = '{mount:0, size:0,       rd:1, wr:0, lba:2047, stall:0, kind:0, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[8]  = '{mount:0, size:0,       rd:1, wr:0, lba:2048, stall:0, kind:1, words:256, rdc:0, wrc:0,  ackc:-1};
    vecs[9]  = '{mount:1, size:4096,    rd:1, wr:0, lba:8,    stall:0, kind:1, words:256, rdc:0, wrc:0,  ackc:-1};
    vecs[10] = '{mount:0, size:0,       rd:0, wr:1, lba:8,    stall:0, kind:3, words:0,   rdc:0, wrc:0,  ackc:1};
    vecs[11] = '{mount:0, size:0,       rd:1, wr:0, lba:7,    stall:0, kind:0, words:256, rdc:8, wrc:0,  ackc:-1};
    vecs[12] = '{mount:1, size:4196,    rd:1, wr:0, lba:8,    stall:0, kind:1, words:256, rdc:0, wrc:0,  ackc:-1};

    repeat (3) @(negedge clk_sys);
    checkOutput("rst_sd_ack", sd_ack, 0);
    checkOutput("rst_buff_wr", sd_buff_wr, 0);
    checkOutput("rst_ddram_read", ddram_read, 0);
    checkOutput("rst_ddram_write", ddram_write, 0);
    checkOutput("rst_burstcount", ddram_burstcount, 0);
    checkOutput("rst_byteenable", ddram_byteenable, 8'hFF);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
      checkVector(vecs[i], $sformatf("v%0d", i));
    end
    checkOutput("stalls_seen", stall_cnt > 0, 1);

    // Request level held past completion must not start a second transfer
    @(negedge clk_sys);
    clearCounters();
    cur_lba = 3; sd_lba = 32'd3; sd_rd = 1'b1;
    for (int n = 0; n < 50 && !sd_ack; n++) @(negedge clk_sys);
    for (int n = 0; n < 40000 && sd_ack; n++) @(negedge clk_sys);
    repeat (20) @(negedge clk_sys);
    checkOutput("held_rd_ack", sd_ack, 0);
    checkOutput("held_rd_ack_rises", ack_rises, 1);
    checkOutput("held_rd_ddram_reads", rd_cmds, 8);
    checkOutput("held_rd_words", rx_cnt, 256);
    sd_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("held_rd_after_drop", ack_rises, 1);

    // Reset in the middle of a read aborts at once; size is forgotten too
    clearCounters();
    cur_lba = 3; sd_lba = 32'd3; sd_rd = 1'b1;
    for (int n = 0; n < 4000 && rx_cnt < 100; n++) @(negedge clk_sys);
    checkOutput("mid_reached_word100", rx_cnt >= 100, 1);
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("mid_rst_ack", sd_ack, 0);
    checkOutput("mid_rst_ddram_read", ddram_read, 0);
    checkOutput("mid_rst_buff_wr", sd_buff_wr, 0);
    sd_rd = 1'b0;
    rd_q.delete();
    gap = 0;
    @(negedge clk_sys);
    reset = 1'b0;
    v = '{mount:0, size:0, rd:1, wr:0, lba:0, stall:0, kind:1, words:256, rdc:0, wrc:0, ackc:-1};
    applyStimulus(v, "post_rst_nosize");
    checkVector(v, "post_rst_nosize");
    v = '{mount:1, size:1048576, rd:1, wr:0, lba:2, stall:0, kind:0, words:256, rdc:8, wrc:0, ackc:-1};
    applyStimulus(v, "post_rst_rd");
    checkVector(v, "post_rst_rd");

    checkOutput("protocol_err", proto_err, 0);
    checkOutput("cmd_stable_err", stable_err, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
